// File: rtl/sram_ctrl_pkg.sv
// Shared types and elaboration helpers for the SRAM arbiter/controller.
package sram_ctrl_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Identity of the port that owns the current access.
  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } gnt_t;

  // A zero-length strobe cannot be sequenced, so it is rejected at elaboration.
  function automatic bit wait_cyc_ok(input int w);
    return (w >= 1);
  endfunction

endpackage

// File: rtl/sram_arb.sv
// Fixed-priority selection between the data and fetch ports, plus the
// registers that hold the winner's request for the length of an access.
module sram_arb
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              gnt_any,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_we,
  output logic [DATA_W-1:0] sel_wdata,
  output logic [ADDR_W-1:0] lat_addr,
  output logic              lat_we,
  output logic [DATA_W-1:0] lat_wdata,
  output gnt_t              lat_gnt
);

  gnt_t sel_gnt;

  // Data port wins ties; a fetch is always a read with no write data.
  always_comb begin
    gnt_any   = d_req | i_req;
    sel_gnt   = GNT_D;
    sel_addr  = d_addr;
    sel_we    = d_we;
    sel_wdata = d_wdata;
    if (!d_req && i_req) begin
      sel_gnt   = GNT_I;
      sel_addr  = i_addr;
      sel_we    = 1'b0;
      sel_wdata = '0;
    end
  end

  // Capture the winner once; port inputs are ignored until the next grant.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_gnt   <= GNT_D;
    end else if (load && gnt_any) begin
      lat_addr  <= sel_addr;
      lat_we    <= sel_we;
      lat_wdata <= sel_wdata;
      lat_gnt   <= sel_gnt;
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Asynchronous-SRAM controller shared by instruction fetch and data access.
// Each access runs SETUP -> STROBE (WAIT_CYC cycles) -> HOLD with an ack in HOLD.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              busy,
  output logic              sram_en_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  if (!wait_cyc_ok(WAIT_CYC)) begin : g_bad_wait
    $error("sram_arb_ctrl: WAIT_CYC must be at least 1");
  end

  localparam int CNT_W = $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              drive;

  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  gnt_t              lat_gnt;

  sram_arb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .load      (state == IDLE),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .gnt_any   (gnt_any),
    .sel_addr  (sel_addr),
    .sel_we    (sel_we),
    .sel_wdata (sel_wdata),
    .lat_addr  (lat_addr),
    .lat_we    (lat_we),
    .lat_wdata (lat_wdata),
    .lat_gnt   (lat_gnt)
  );

  // The bus is released except while a write owns it; the drive enable is a register.
  assign sram_data = drive ? lat_wdata : {DATA_W{1'bz}};

  // Access sequencer: every pin, ack and rdata is a register updated here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      drive     <= 1'b0;
      sram_en_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_addr <= '0;
      d_ack     <= 1'b0;
      i_ack     <= 1'b0;
      d_rdata   <= '0;
      i_rdata   <= '0;
    end else begin
      d_ack <= 1'b0;
      i_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state     <= SETUP;
            busy      <= 1'b1;
            sram_en_n <= 1'b0;
            sram_addr <= sel_addr;
            drive     <= sel_we;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CNT_LOAD;
          if (lat_we) sram_we_n <= 1'b0;
          else        sram_oe_n <= 1'b0;
        end
        STROBE: begin
          if (cnt == '0) begin
            state     <= HOLD;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!lat_we) begin
              if (lat_gnt == GNT_D) d_rdata <= sram_data;
              else                  i_rdata <= sram_data;
            end
            if (lat_gnt == GNT_D) d_ack <= 1'b1;
            else                  i_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          busy      <= 1'b0;
          sram_en_n <= 1'b1;
          drive     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl with a small behavioural SRAM model.
module tb_sram_arb_ctrl;

  localparam int DW = 16;
  localparam int AW = 18;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          d_req = 1'b0, d_we = 1'b0, i_req = 1'b0;
  logic [AW-1:0] d_addr = '0, i_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack, i_ack, busy, sram_en_n, sram_oe_n, sram_we_n;
  logic [DW-1:0] d_rdata, i_rdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  // Second instance with a three-cycle strobe.
  logic          d_req3 = 1'b0;
  logic          d_ack3, i_ack3, busy3, en_n3, oe_n3, we_n3;
  logic [DW-1:0] d_rdata3, i_rdata3;
  logic [AW-1:0] addr3;
  wire  [DW-1:0] data3;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] zz = 'z;

  int total = 0;
  int bad   = 0;
  int oe_lo;

  always #5 CLK = ~CLK;

  sram_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(1)) dut (
    .CLK(CLK), .RST(RST),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .busy(busy), .sram_en_n(sram_en_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_addr(sram_addr), .sram_data(sram_data)
  );

  sram_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(3)) dut3 (
    .CLK(CLK), .RST(RST),
    .d_req(d_req3), .d_we(1'b0), .d_addr(18'h00040), .d_wdata(16'h0000),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .i_req(1'b0), .i_addr(18'h00000), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .busy(busy3), .sram_en_n(en_n3), .sram_oe_n(oe_n3),
    .sram_we_n(we_n3), .sram_addr(addr3), .sram_data(data3)
  );

  // SRAM models: drive while enabled with output enable low.
  assign sram_data = (!sram_en_n && !sram_oe_n) ? mem[sram_addr[7:0]] : {DW{1'bz}};
  assign data3     = (!en_n3 && !oe_n3) ? 16'h3C3C : {DW{1'bz}};

  // Write lands on the rising edge of the write strobe.
  always @(posedge sram_we_n) begin
    if (sram_en_n === 1'b0) mem[sram_addr[7:0]] <= sram_data;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = '0;
    mem[8'h40] = 16'h2222;

    // Reset with random inputs.
    for (int k = 0; k < 4; k++) begin
      d_req = 1'($urandom); d_we = 1'($urandom); i_req = 1'($urandom);
      d_addr = AW'($urandom); i_addr = AW'($urandom); d_wdata = DW'($urandom);
      step();
    end
    check("rst_en_n", sram_en_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_data", sram_data, zz);
    check("rst_acks", {d_ack, i_ack}, 0);
    check("rst_rdata", {d_rdata, i_rdata}, 0);
    check("rst_busy", busy, 0);
    check("rst_w3", {busy3, en_n3, oe_n3, we_n3, d_ack3}, 5'b01110);
    d_req = 0; i_req = 0; d_we = 0; d_addr = '0; i_addr = '0; d_wdata = '0;
    step();
    RST = 1'b1;
    step();

    // Write 0xBEEF to 0x00123.
    d_req = 1; d_we = 1; d_addr = 18'h00123; d_wdata = 16'hBEEF;
    step();
    check("wr_c1_addr", sram_addr, 18'h00123);
    check("wr_c1_ctl", {sram_en_n, sram_oe_n, sram_we_n, busy}, 4'b0111);
    check("wr_c1_data", sram_data, 16'hBEEF);
    step();
    check("wr_c2_ctl", {sram_oe_n, sram_we_n, d_ack}, 3'b100);
    check("wr_c2_data", sram_data, 16'hBEEF);
    step();
    check("wr_c3_ctl", {sram_en_n, sram_oe_n, sram_we_n, d_ack}, 4'b0111);
    check("wr_c3_data", sram_data, 16'hBEEF);
    d_req = 0;
    step();
    check("wr_c4_idle", {d_ack, busy, sram_en_n}, 3'b001);
    check("wr_c4_data", sram_data, zz);

    // Read back 0x00123.
    d_req = 1; d_we = 0; d_addr = 18'h00123; d_wdata = 16'h0000;
    step();
    check("rd_c1_ctl", {sram_en_n, sram_oe_n, sram_we_n}, 3'b011);
    check("rd_c1_data", sram_data, zz);
    step();
    check("rd_c2_ctl", {sram_oe_n, sram_we_n}, 2'b01);
    check("rd_c2_bus", sram_data, 16'hBEEF);
    step();
    check("rd_c3_ack", {d_ack, sram_oe_n}, 2'b11);
    check("rd_c3_rdata", d_rdata, 16'hBEEF);
    d_req = 0;
    step();

    // Contention: data write and fetch in the same cycle.
    d_req = 1; d_we = 1; d_addr = 18'h00001; d_wdata = 16'h1111;
    i_req = 1; i_addr = 18'h00040;
    step();
    check("ct_c1_addr", sram_addr, 18'h00001);
    step();
    step();
    check("ct_c3_acks", {d_ack, i_ack}, 2'b10);
    d_req = 0;
    step();
    check("ct_c4_idle", {busy, i_ack}, 2'b00);
    step();
    check("ct_c5_addr", sram_addr, 18'h00040);
    step();
    check("ct_c6_oe", {sram_oe_n, i_ack}, 2'b00);
    step();
    check("ct_c7_acks", {d_ack, i_ack}, 2'b01);
    check("ct_c7_irdata", i_rdata, 16'h2222);
    check("ct_c7_drdata", d_rdata, 16'hBEEF);
    i_req = 0;
    step();
    check("ct_mem1", mem[8'h01], 16'h1111);

    // Three-cycle strobe read on the second instance.
    d_req3 = 1;
    oe_lo = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (oe_n3 == 1'b0) oe_lo++;
      if (c == 4) check("w3_c4_noack", d_ack3, 0);
      if (c == 5) begin
        check("w3_c5_ack", d_ack3, 1);
        check("w3_c5_rdata", d_rdata3, 16'h3C3C);
        d_req3 = 0;
      end
    end
    check("w3_oe_cycles", oe_lo, 3);

    // Reset during the strobe of a write.
    d_req = 1; d_we = 1; d_addr = 18'h00077; d_wdata = 16'hAAAA;
    step();
    step();
    check("rm_c2_we", sram_we_n, 0);
    #2;
    RST = 1'b0;
    #1;
    check("rm_ctl", {sram_en_n, sram_we_n, sram_oe_n, busy}, 4'b1110);
    check("rm_data", sram_data, zz);
    check("rm_addr", sram_addr, 0);
    check("rm_rdata", {d_rdata, i_rdata}, 0);
    d_req = 0;
    step();
    step();
    check("rm_noack", d_ack, 0);
    RST = 1'b1;
    step();

    // Fresh write after reset release, then read it back.
    d_req = 1; d_we = 1; d_addr = 18'h00050; d_wdata = 16'h5555;
    step();
    check("pw_c1_addr", sram_addr, 18'h00050);
    step();
    check("pw_c2_we", sram_we_n, 0);
    step();
    check("pw_c3_ack", d_ack, 1);
    d_req = 0;
    step();
    d_req = 1; d_we = 0; d_addr = 18'h00050;
    step();
    step();
    step();
    check("pr_c3_rdata", {d_ack, d_rdata}, {1'b1, 16'h5555});
    d_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
